// File: rtl/axi_wr_arb_request_mux.sv
// Write-path front end for the round-robin arbiter: snapshots pending AW requests,
// validates the returned grant and routes one master's AW/B channels to the slave.
module axi_wr_arb_request_mux #(
  parameter int MST_NUM    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  localparam int IW        = (MST_NUM > 1) ? $clog2(MST_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [MST_NUM-1:0]              s_awvalid,
  input  logic [MST_NUM*ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [MST_NUM*LEN_WIDTH-1:0]    s_awlen,
  input  logic [MST_NUM*ID_WIDTH-1:0]     s_awid,
  output logic [MST_NUM-1:0]              s_awready,
  output logic [MST_NUM-1:0]              s_bvalid,
  output logic [1:0]                      s_bresp,
  output logic [ID_WIDTH-1:0]             s_bid,
  input  logic [MST_NUM-1:0]              s_bready,
  output logic                            m_awvalid,
  output logic [ADDR_WIDTH-1:0]           m_awaddr,
  output logic [LEN_WIDTH-1:0]            m_awlen,
  output logic [ID_WIDTH-1:0]             m_awid,
  input  logic                            m_awready,
  input  logic                            m_bvalid,
  input  logic [1:0]                      m_bresp,
  input  logic [ID_WIDTH-1:0]             m_bid,
  output logic                            m_bready,
  output logic                            arb_rd_wr_flag,
  output logic [MST_NUM-1:0]              arb_request,
  output logic                            arb_request_valid,
  input  logic [MST_NUM-1:0]              arb_grant,
  input  logic [IW-1:0]                   arb_grant_index,
  input  logic                            arb_grant_valid,
  output logic [IW-1:0]                   sel_index,
  output logic                            grant_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_GNT = 3'd2,
    ADDR     = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [MST_NUM-1:0]   req_nxt;
  logic                 req_vld_nxt;
  logic [IW-1:0]        sel_nxt;
  logic                 err_nxt;

  logic [MST_NUM-1:0]    sel_onehot;
  logic                  sel_awvalid;
  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic [LEN_WIDTH-1:0]  sel_awlen;
  logic [ID_WIDTH-1:0]   sel_awid;
  logic                  sel_bready;

  // A grant is accepted only if it is one-hot, agrees with its index and
  // names a master that was actually in the snapshot.
  function automatic logic grant_ok(input logic [MST_NUM-1:0] gnt,
                                    input logic [IW-1:0]      idx,
                                    input logic [MST_NUM-1:0] req);
    int   ones;
    logic hit;
    ones = 0;
    hit  = 1'b0;
    for (int i = 0; i < MST_NUM; i++) begin
      ones = ones + int'(gnt[i]);
      if (idx == IW'(i)) hit = gnt[i] & req[i];
    end
    return (ones == 1) && hit;
  endfunction

  assign arb_rd_wr_flag = 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      arb_request       <= '0;
      arb_request_valid <= 1'b0;
      sel_index         <= '0;
      grant_err         <= 1'b0;
    end else begin
      state             <= state_nxt;
      arb_request       <= req_nxt;
      arb_request_valid <= req_vld_nxt;
      sel_index         <= sel_nxt;
      grant_err         <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = arb_request;
    sel_nxt   = sel_index;
    err_nxt   = grant_err;
    case (state)
      IDLE: begin
        if (|s_awvalid) begin
          req_nxt   = s_awvalid;
          state_nxt = REQ;
        end
      end
      REQ: state_nxt = WAIT_GNT;
      WAIT_GNT: begin
        if (arb_grant_valid) begin
          if (grant_ok(arb_grant, arb_grant_index, arb_request)) begin
            sel_nxt   = arb_grant_index;
            state_nxt = ADDR;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      ADDR: if (m_awvalid && m_awready) state_nxt = RESP;
      RESP: if (m_bvalid && m_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The strobe is a flop so it is high exactly for the cycle spent in REQ.
    req_vld_nxt = (state_nxt == REQ);
  end

  always_comb begin
    sel_onehot  = '0;
    sel_awvalid = 1'b0;
    sel_awaddr  = '0;
    sel_awlen   = '0;
    sel_awid    = '0;
    sel_bready  = 1'b0;
    for (int i = 0; i < MST_NUM; i++) begin
      if (sel_index == IW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_awvalid   = s_awvalid[i];
        sel_awaddr    = s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_awlen     = s_awlen[i*LEN_WIDTH +: LEN_WIDTH];
        sel_awid      = s_awid[i*ID_WIDTH +: ID_WIDTH];
        sel_bready    = s_bready[i];
      end
    end
  end

  // B is gated outside RESP so an early slave BVALID simply waits.
  always_comb begin
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awid    = '0;
    s_awready = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    s_bid     = '0;
    m_bready  = 1'b0;
    if (state == ADDR) begin
      m_awvalid = sel_awvalid;
      m_awaddr  = sel_awaddr;
      m_awlen   = sel_awlen;
      m_awid    = sel_awid;
      s_awready = sel_onehot & {MST_NUM{m_awready}};
    end
    if (state == RESP) begin
      s_bvalid = sel_onehot & {MST_NUM{m_bvalid}};
      m_bready = sel_bready;
      s_bresp  = m_bresp;
      s_bid    = m_bid;
    end
  end

endmodule

// File: tb/tb_axi_wr_arb_request_mux.sv
// Bench for axi_wr_arb_request_mux: table of arbitration rounds plus a reset-in-RESP
// sequence; AW and B handshakes are checked against queued expectations.
module tb_axi_wr_arb_request_mux;

  localparam int MST_NUM    = 3;
  localparam int ADDR_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int LEN_WIDTH  = 8;
  localparam int IW         = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [MST_NUM-1:0]            s_awvalid;
  logic [MST_NUM*ADDR_WIDTH-1:0] s_awaddr;
  logic [MST_NUM*LEN_WIDTH-1:0]  s_awlen;
  logic [MST_NUM*ID_WIDTH-1:0]   s_awid;
  logic [MST_NUM-1:0]            s_awready;
  logic [MST_NUM-1:0]            s_bvalid;
  logic [1:0]                    s_bresp;
  logic [ID_WIDTH-1:0]           s_bid;
  logic [MST_NUM-1:0]            s_bready;
  logic                          m_awvalid;
  logic [ADDR_WIDTH-1:0]         m_awaddr;
  logic [LEN_WIDTH-1:0]          m_awlen;
  logic [ID_WIDTH-1:0]           m_awid;
  logic                          m_awready;
  logic                          m_bvalid;
  logic [1:0]                    m_bresp;
  logic [ID_WIDTH-1:0]           m_bid;
  logic                          m_bready;
  logic                          arb_rd_wr_flag;
  logic [MST_NUM-1:0]            arb_request;
  logic                          arb_request_valid;
  logic [MST_NUM-1:0]            arb_grant;
  logic [IW-1:0]                 arb_grant_index;
  logic                          arb_grant_valid;
  logic [IW-1:0]                 sel_index;
  logic                          grant_err;

  axi_wr_arb_request_mux #(
    .MST_NUM(MST_NUM), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awid(s_awid),
    .s_awready(s_awready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_bready(s_bready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid),
    .m_awready(m_awready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_bready(m_bready),
    .arb_rd_wr_flag(arb_rd_wr_flag), .arb_request(arb_request),
    .arb_request_valid(arb_request_valid), .arb_grant(arb_grant),
    .arb_grant_index(arb_grant_index), .arb_grant_valid(arb_grant_valid),
    .sel_index(sel_index), .grant_err(grant_err)
  );

  typedef struct {
    logic [2:0] pend_add;
    logic [2:0] snap;
    logic [2:0] gnt;
    logic [1:0] gidx;
    logic       ok;
    logic       err;
    int         aw_stall;
    int         b_stall;
    logic       early_b;
  } vec_t;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [ID_WIDTH-1:0]   id;
  } aw_t;

  typedef struct {
    logic [2:0]          mask;
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
  } b_t;

  aw_t aw_q[$];
  b_t  b_q[$];
  aw_t aw_e;
  b_t  b_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [ADDR_WIDTH-1:0] addr_of [MST_NUM];
  logic [LEN_WIDTH-1:0]  len_of  [MST_NUM];
  logic [ID_WIDTH-1:0]   id_of   [MST_NUM];
  vec_t vecs [8];
  vec_t rst_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && m_awvalid && m_awready) begin
      if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
      else begin
        aw_e = aw_q.pop_front();
        check("aw_addr", m_awaddr, aw_e.addr);
        check("aw_len", m_awlen, aw_e.len);
        check("aw_id", m_awid, aw_e.id);
      end
    end
    if (rstn && m_bvalid && m_bready) begin
      if (b_q.size() == 0) check("b_unexpected", 1, 0);
      else begin
        b_e = b_q.pop_front();
        check("b_route", s_bvalid, b_e.mask);
        check("b_id", s_bid, b_e.bid);
        check("b_resp", s_bresp, b_e.bresp);
      end
    end
  end

  task automatic wait_strobe(input int r);
    int k;
    k = 0;
    while (!arb_request_valid && k < 20) begin
      step();
      k++;
    end
    check($sformatf("r%0d_strobe_seen", r), arb_request_valid, 1);
  endtask

  task automatic do_round(input vec_t v, input int r);
    aw_t        a;
    b_t         b;
    logic [2:0] oh;
    oh = 3'b001 << v.gidx;
    s_awvalid = s_awvalid | v.pend_add;
    wait_strobe(r);
    if (!arb_request_valid) return;
    check($sformatf("r%0d_snapshot", r), arb_request, v.snap);
    check("wr_flag", arb_rd_wr_flag, 1);
    step();
    // WAIT_GNT: arbiter answers one cycle after the strobe
    check($sformatf("r%0d_strobe_width", r), arb_request_valid, 0);
    arb_grant = v.gnt;
    arb_grant_index = v.gidx;
    arb_grant_valid = 1'b1;
    if (v.ok) begin
      a.addr = addr_of[v.gidx];
      a.len  = len_of[v.gidx];
      a.id   = id_of[v.gidx];
      aw_q.push_back(a);
    end
    step();
    arb_grant_valid = 1'b0;
    arb_grant = '0;
    arb_grant_index = '0;
    check($sformatf("r%0d_grant_err", r), grant_err, v.err);
    if (!v.ok) begin
      check($sformatf("r%0d_no_awvalid", r), m_awvalid, 0);
      step();
      check($sformatf("r%0d_rerequest", r), arb_request_valid, 1);
      return;
    end
    check($sformatf("r%0d_awvalid", r), m_awvalid, 1);
    check($sformatf("r%0d_sel_index", r), sel_index, v.gidx);
    if (v.early_b) begin
      m_bvalid = 1'b1;
      m_bid = id_of[v.gidx];
      m_bresp = 2'(r);
      s_bready = 3'b111;
      #1;
      check($sformatf("r%0d_early_bready", r), m_bready, 0);
      check($sformatf("r%0d_early_bvalid", r), s_bvalid, 0);
      s_bready = 3'b000;
    end
    for (int i = 0; i < v.aw_stall; i++) begin
      check($sformatf("r%0d_stall_awvalid", r), m_awvalid, 1);
      check($sformatf("r%0d_stall_addr", r), m_awaddr, addr_of[v.gidx]);
      check($sformatf("r%0d_stall_len", r), m_awlen, len_of[v.gidx]);
      check($sformatf("r%0d_stall_awready", r), s_awready, 0);
      step();
    end
    m_awready = 1'b1;
    #1;
    check($sformatf("r%0d_awready_route", r), s_awready, oh);
    step();
    m_awready = 1'b0;
    s_awvalid[v.gidx] = 1'b0;
    // RESP: other masters' BREADY must not leak through while stalled
    m_bvalid = 1'b1;
    m_bid = id_of[v.gidx];
    m_bresp = 2'(r);
    s_bready = ~oh;
    for (int i = 0; i < v.b_stall; i++) begin
      #1;
      check($sformatf("r%0d_bstall_bvalid", r), s_bvalid, oh);
      check($sformatf("r%0d_bstall_bready", r), m_bready, 0);
      step();
    end
    s_bready = oh;
    b.mask = oh;
    b.bid = id_of[v.gidx];
    b.bresp = 2'(r);
    b_q.push_back(b);
    #1;
    check($sformatf("r%0d_bready", r), m_bready, 1);
    step();
    m_bvalid = 1'b0;
    s_bready = '0;
    #1;
    check($sformatf("r%0d_idle_gap", r), arb_request_valid, 0);
    check($sformatf("r%0d_bvalid_off", r), s_bvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_of[0] = 32'h0000_0A00; len_of[0] = 8'd5;   id_of[0] = 4'h2;
    addr_of[1] = 32'h0000_1000; len_of[1] = 8'd3;   id_of[1] = 4'h7;
    addr_of[2] = 32'h2000_0040; len_of[2] = 8'hFF;  id_of[2] = 4'hC;
    //            add     snap    gnt     idx   ok    err   aws bs  early
    vecs[0] = '{3'b010, 3'b010, 3'b010, 2'd1, 1'b1, 1'b0, 0, 0, 1'b0};
    vecs[1] = '{3'b111, 3'b111, 3'b001, 2'd0, 1'b1, 1'b0, 0, 0, 1'b0};
    vecs[2] = '{3'b000, 3'b110, 3'b010, 2'd1, 1'b1, 1'b0, 0, 1, 1'b0};
    vecs[3] = '{3'b000, 3'b100, 3'b100, 2'd2, 1'b1, 1'b0, 5, 4, 1'b0};
    vecs[4] = '{3'b001, 3'b001, 3'b011, 2'd0, 1'b0, 1'b1, 0, 0, 1'b0};
    vecs[5] = '{3'b000, 3'b001, 3'b100, 2'd2, 1'b0, 1'b1, 0, 0, 1'b0};
    vecs[6] = '{3'b000, 3'b001, 3'b001, 2'd0, 1'b1, 1'b1, 2, 2, 1'b1};
    vecs[7] = '{3'b100, 3'b100, 3'b100, 2'd2, 1'b1, 1'b1, 1, 1, 1'b1};
    rst_vec = '{3'b000, 3'b010, 3'b010, 2'd1, 1'b1, 1'b0, 0, 1, 1'b0};

    s_awvalid = '0;
    s_awaddr = {addr_of[2], addr_of[1], addr_of[0]};
    s_awlen  = {len_of[2], len_of[1], len_of[0]};
    s_awid   = {id_of[2], id_of[1], id_of[0]};
    s_bready = '0;
    m_awready = 1'b0;
    m_bvalid = 1'b0;
    m_bresp = '0;
    m_bid = '0;
    arb_grant = '0;
    arb_grant_index = '0;
    arb_grant_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_request", arb_request, 0);
    check("rst_request_valid", arb_request_valid, 0);
    check("rst_sel_index", sel_index, 0);
    check("rst_grant_err", grant_err, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_bready", m_bready, 0);
    rstn = 1'b1;
    step();

    for (int r = 0; r < 8; r++) do_round(vecs[r], r);

    // Reset in RESP clears everything, including the sticky error
    s_awvalid = 3'b010;
    wait_strobe(8);
    check("r8_snapshot", arb_request, 3'b010);
    step();
    arb_grant = 3'b010;
    arb_grant_index = 2'd1;
    arb_grant_valid = 1'b1;
    aw_e.addr = addr_of[1];
    aw_e.len = len_of[1];
    aw_e.id = id_of[1];
    aw_q.push_back(aw_e);
    step();
    arb_grant_valid = 1'b0;
    arb_grant = '0;
    arb_grant_index = '0;
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
    m_bvalid = 1'b1;
    m_bid = id_of[1];
    m_bresp = 2'b10;
    s_bready = 3'b010;
    #1;
    check("r8_resp_bvalid", s_bvalid, 3'b010);
    check("r8_err_before_rst", grant_err, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_bvalid", s_bvalid, 0);
    check("mid_rst_bready", m_bready, 0);
    check("mid_rst_bid", s_bid, 0);
    check("mid_rst_grant_err", grant_err, 0);
    check("mid_rst_sel_index", sel_index, 0);
    check("mid_rst_request", arb_request, 0);
    check("mid_rst_awready", s_awready, 0);
    m_bvalid = 1'b0;
    s_bready = '0;
    step();
    step();
    rstn = 1'b1;
    do_round(rst_vec, 9);

    step();
    check("aw_queue_empty", aw_q.size(), 0);
    check("b_queue_empty", b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_arb_request_mux.md
Name: axi_wr_arb_request_mux

Overview:
- Upstream/downstream companion of round_robin_priority_arbiter on the AXI interconnect write path.
- Collects AW requests from MST_NUM masters and presents them to the arbiter as a one-cycle request snapshot with rd_wr_flag=1.
- Takes the arbiter's grant and routes the winning master's AW channel to the single slave port.
- Holds the selection until that master's B response completes, then returns to idle.

Parameters:
- MST_NUM, 3, number of masters; must equal the arbiter's REQ_NUM.
- ADDR_WIDTH, 32, AW address width.
- ID_WIDTH, 4, AWID/BID width.
- LEN_WIDTH, 8, AWLEN width.
- IW, $clog2(MST_NUM), derived; not overridable.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- s_awvalid  in  MST_NUM  per-master AWVALID.
- s_awaddr  in  MST_NUM*ADDR_WIDTH  packed; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_awlen  in  MST_NUM*LEN_WIDTH  packed, same scheme.
- s_awid  in  MST_NUM*ID_WIDTH  packed, same scheme.
- s_awready  out  MST_NUM  per-master AWREADY.
- s_bvalid  out  MST_NUM  per-master BVALID.
- s_bresp  out  2  BRESP broadcast to all masters.
- s_bid  out  ID_WIDTH  BID broadcast to all masters.
- s_bready  in  MST_NUM  per-master BREADY.
- m_awvalid  out  1  slave-side AWVALID.
- m_awaddr  out  ADDR_WIDTH  slave-side AWADDR.
- m_awlen  out  LEN_WIDTH  slave-side AWLEN.
- m_awid  out  ID_WIDTH  slave-side AWID.
- m_awready  in  1  slave-side AWREADY.
- m_bvalid  in  1  slave-side BVALID.
- m_bresp  in  2  slave-side BRESP.
- m_bid  in  ID_WIDTH  slave-side BID.
- m_bready  out  1  slave-side BREADY.
- arb_rd_wr_flag  out  1  to arbiter; constant 1 (write).
- arb_request  out  MST_NUM  to arbiter; request snapshot.
- arb_request_valid  out  1  to arbiter; one-cycle strobe.
- arb_grant  in  MST_NUM  from arbiter; one-hot grant.
- arb_grant_index  in  IW  from arbiter; grant index.
- arb_grant_valid  in  1  from arbiter; grant strobe.
- sel_index  out  IW  currently selected master.
- grant_err  out  1  sticky grant-error flag.

Behaviour:
- Reset (rstn low, async): state=IDLE; arb_request=0; arb_request_valid=0; sel_index=0; grant_err=0. All AW/B outputs to masters and slave are 0.
- FSM states: IDLE, REQ, WAIT_GNT, ADDR, RESP.
- IDLE:
  - If |s_awvalid, register arb_request<=s_awvalid and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - arb_request_valid=1 for exactly this cycle (registered).
  - Go to WAIT_GNT.
- WAIT_GNT:
  - Wait for arb_grant_valid; there is no timeout.
  - Grant is valid when arb_grant is one-hot, arb_grant[arb_grant_index]=1, and arb_request[arb_grant_index]=1. On a valid grant: sel_index<=arb_grant_index, go to ADDR.
  - Any other grant: set grant_err (sticky until reset), go to IDLE, and re-request next cycle if AW is still pending.
- ADDR:
  - m_awvalid=s_awvalid[sel_index].
  - m_awaddr/m_awlen/m_awid are combinationally muxed from master sel_index.
  - s_awready[sel_index]=m_awready; all other s_awready bits are 0.
  - On handshake (m_awvalid & m_awready), go to RESP.
  - If the master drops AWVALID before the handshake (AXI violation), stay in ADDR.
- RESP:
  - s_bvalid[sel_index]=m_bvalid; other s_bvalid bits are 0.
  - m_bready=s_bready[sel_index].
  - s_bresp=m_bresp and s_bid=m_bid, presented to all masters.
  - On handshake (m_bvalid & m_bready), go to IDLE.
- Outside RESP: m_bready=0 and all s_bvalid=0. A slave BVALID arriving early is held off, not dropped.
- Non-granted masters never see AWREADY; their AWVALID stays pending, and they are served in a later round.
- Minimum cycles from AW request to slave AWVALID:
  - 3 if the arbiter responds in the cycle after the strobe: IDLE→REQ, REQ→WAIT_GNT, grant in WAIT_GNT.
  - Plus arbiter latency otherwise.
- Only one outstanding write transaction at a time.
- After a B handshake the block returns to IDLE for one cycle before a new snapshot is taken (no back-to-back bypass).
- Reset asserted mid-transaction: all outputs drop immediately. After release, pending s_awvalid is re-arbitrated from IDLE.
- arb_grant_valid arriving in any state other than WAIT_GNT is ignored.

Test Plan:
- Single master: s_awvalid=3'b010, awaddr=0x1000, awlen=3; arbiter grants index 1 one cycle after the strobe → arb_request=3'b010, one-cycle arb_request_valid, m_awaddr=0x1000, m_awlen=3, only s_awready[1] pulses; BVALID routes only to s_bvalid[1].
- All three masters pending, arbiter returns 0, 1, 2 over successive rounds → three complete transactions in that order, each starting only after the previous B handshake. Each snapshot contains only masters that are still pending.
- Invalid grant: arb_grant=3'b011, or index 2 with snapshot 3'b001 → grant_err=1, m_awvalid never asserts, re-request on the next cycle.
- Slave back-pressure: m_awready low for 5 cycles, then BVALID held 4 cycles with s_bready low → no state change and stable m_aw* fields; completion only on the respective handshakes.
- Early BVALID asserted during ADDR → m_bready=0 and s_bvalid=0 until RESP.
- Reset asserted in RESP → all outputs 0 and grant_err cleared; after release with s_awvalid still set, the FSM restarts from IDLE with a new snapshot.
